// File: rtl/ultra_wide_result_serializer_if.sv
// Result-side bundle of the ultra-wide serializer: 128-bit strobe in, 32-bit beat stream out,
// plus occupancy and the sticky overflow flag.
interface ultra_wide_result_serializer_if #(
    parameter int DEPTH = 4
);
    logic                     in_vld;
    logic [127:0]             in_data;
    logic                     out_vld;
    logic                     out_rdy;
    logic [31:0]              out_data;
    logic                     out_last;
    logic [$clog2(DEPTH):0]   level;
    logic                     ovf_r;
    logic                     ovf_clr;

    modport master (
        output in_vld, in_data, out_rdy, ovf_clr,
        input  out_vld, out_data, out_last, level, ovf_r
    );

    modport slave (
        input  in_vld, in_data, out_rdy, ovf_clr,
        output out_vld, out_data, out_last, level, ovf_r
    );
endinterface

// File: rtl/ultra_wide_result_serializer.sv
// Captures non-backpressurable 128-bit results into a FIFO and replays each entry as four
// 32-bit beats, least-significant word first; results arriving while full are dropped.
module ultra_wide_result_serializer #(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    ultra_wide_result_serializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    beat;
    logic          ovf_q;

    logic full;
    logic xfer;
    logic pop;
    logic push;
    logic drop;

    assign full = (count == CW'(DEPTH));
    assign xfer = bus.out_vld & bus.out_rdy;
    assign pop  = xfer & (beat == 2'd3);
    // A full FIFO still accepts a result when the head's last beat leaves this cycle.
    assign push = bus.in_vld & (~full | pop);
    assign drop = bus.in_vld & ~push;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beat   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            // Beat wraps 3->0 naturally, so a pop always leaves the next head at beat 0.
            if (xfer) beat <= beat + 2'd1;
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= bus.in_data;
    end

    assign bus.out_vld  = (count != '0);
    assign bus.out_last = bus.out_vld & (beat == 2'd3);
    assign bus.out_data = mem[rd_ptr][{beat, 5'b0} +: 32];
    assign bus.level    = count;
    assign bus.ovf_r    = ovf_q;
endmodule
